// File: rtl/modulus_count_checker.sv
// Sequence checker for a modulo-N counter: predicts each sample from the
// previous one and reports lock, mismatch pulses, error and wrap counts.
module modulus_count_checker #(
  parameter int WIDTH       = 3,
  parameter int MODULUS     = 6,
  parameter int LOCK_THRESH = 2,
  parameter int LOSS_THRESH = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable,
  input  logic [WIDTH-1:0] count,
  output logic             sync_ok,
  output logic             error,
  output logic             err_sticky,
  output logic [7:0]       err_count,
  output logic [7:0]       wrap_count
);

  typedef enum logic [1:0] {
    ACQ,
    VERIFY,
    TRACK
  } state_t;

  localparam logic [WIDTH-1:0] TOP    = WIDTH'(MODULUS - 1);
  localparam logic [WIDTH:0]   MOD_W  = (WIDTH + 1)'(MODULUS);
  localparam logic [7:0]       LOCK_T = 8'(LOCK_THRESH);
  localparam logic [7:0]       LOSS_T = 8'(LOSS_THRESH);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] prev_count, pc_d;
  logic             prev_en, pe_d;
  logic             prev_valid, pv_d;
  logic [7:0]       good_run, good_d;
  logic [7:0]       bad_run, bad_d;
  logic             err_d, sticky_d;
  logic [7:0]       errc_d, wrap_d;

  logic [WIDTH-1:0] pred;
  logic             oor;
  logic             mism;

  assign pred = prev_en ? ((prev_count == TOP) ? '0
                                               : prev_count + WIDTH'(1))
                        : prev_count;
  assign oor  = {1'b0, count} >= MOD_W;
  assign mism = (prev_valid && (count != pred)) || oor;

  assign sync_ok = (state_q == TRACK);

  always_comb begin
    state_d  = state_q;
    pc_d     = prev_count;
    pe_d     = prev_en;
    pv_d     = prev_valid;
    good_d   = good_run;
    bad_d    = bad_run;
    err_d    = 1'b0;
    sticky_d = err_sticky;
    errc_d   = err_count;
    wrap_d   = wrap_count;
    unique case (state_q)
      ACQ: begin
        if (!oor) begin
          pc_d    = count;
          pe_d    = enable;
          pv_d    = 1'b1;
          good_d  = '0;
          state_d = VERIFY;
        end else begin
          pv_d = 1'b0;
        end
      end
      VERIFY: begin
        // an in-range miss becomes the new reference right away
        if (mism) begin
          good_d = '0;
          if (oor) begin
            pv_d    = 1'b0;
            state_d = ACQ;
          end else begin
            pc_d = count;
            pe_d = enable;
          end
        end else begin
          pc_d   = count;
          pe_d   = enable;
          good_d = (good_run == 8'hff) ? good_run : good_run + 8'd1;
          if (good_d >= LOCK_T) begin
            bad_d   = '0;
            state_d = TRACK;
          end
        end
      end
      TRACK: begin
        if (mism) begin
          err_d    = 1'b1;
          sticky_d = 1'b1;
          errc_d   = (err_count == 8'hff) ? err_count : err_count + 8'd1;
          bad_d    = (bad_run == 8'hff) ? bad_run : bad_run + 8'd1;
          if (!oor) begin
            pc_d = count;
            pe_d = enable;
          end
          if (bad_d >= LOSS_T) begin
            pv_d    = 1'b0;
            state_d = ACQ;
          end
        end else begin
          bad_d = '0;
          pc_d  = count;
          pe_d  = enable;
          if (prev_en && (prev_count == TOP) && (count == '0))
            wrap_d = wrap_count + 8'd1;
        end
      end
      default: state_d = ACQ;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= ACQ;
      prev_count <= '0;
      prev_en    <= 1'b0;
      prev_valid <= 1'b0;
      good_run   <= '0;
      bad_run    <= '0;
      error      <= 1'b0;
      err_sticky <= 1'b0;
      err_count  <= '0;
      wrap_count <= '0;
    end else begin
      state_q    <= state_d;
      prev_count <= pc_d;
      prev_en    <= pe_d;
      prev_valid <= pv_d;
      good_run   <= good_d;
      bad_run    <= bad_d;
      error      <= err_d;
      err_sticky <= sticky_d;
      err_count  <= errc_d;
      wrap_count <= wrap_d;
    end
  end

endmodule
